// File: rtl/arm_data_bus.sv
// Data-side memory subsystem behind the arm core: word RAM plus a memory-mapped
// camera pixel FIFO with capture enable, sticky overflow and a frame counter/interrupt.
module arm_data_bus #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ALUResult,
  input  logic [31:0]      WriteData,
  input  logic             write_enable,
  output logic [31:0]      ReadData,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             frame_start,
  output logic             irq_frame
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;

  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_PIX    = 2'd1;
  localparam logic [1:0] REG_POP    = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic              ram_hit;
  logic              mmio_hit;
  logic [1:0]        reg_sel;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit  = (ALUResult < RAM_BYTES);
  assign mmio_hit = (ALUResult[31:4] == 28'h0000100);
  assign reg_sel  = ALUResult[3:2];
  assign ram_idx  = ALUResult[RAM_AW+1:2];

  logic ctrl_wr;
  logic pop_wr;
  logic flush;
  logic ovf_clr;

  assign ctrl_wr = write_enable && mmio_hit && (reg_sel == REG_CTRL);
  assign pop_wr  = write_enable && mmio_hit && (reg_sel == REG_POP);
  assign flush   = ctrl_wr && WriteData[2];
  assign ovf_clr = ctrl_wr && WriteData[1];

  // ---------------------------------------------------------------------------
  // Data RAM: asynchronous read, contents survive reset
  // ---------------------------------------------------------------------------
  logic [31:0] ram_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (write_enable && ram_hit) begin
      ram_q[ram_idx] <= WriteData;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel FIFO state
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic             cap_en_q, cap_en_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             irq_q,    irq_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ovf_set;
  logic frame_hit;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // A flush write closes the door for the same cycle so no pixel lands in a
  // FIFO that is being emptied underneath it.
  assign pix_ready = cap_en_q && !full && !flush;
  assign push      = pix_valid && pix_ready;
  assign pop       = pop_wr && !empty && !flush;
  assign ovf_set   = pix_valid && cap_en_q && full;
  assign frame_hit = frame_start && cap_en_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    cap_en_d    = cap_en_q;
    frame_cnt_d = frame_cnt_q;
    irq_d       = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Set has priority so a pixel dropped during a clear is never lost silently.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (ctrl_wr) begin
      cap_en_d = WriteData[0];
    end

    if (frame_hit) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      irq_d       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      cap_en_q    <= 1'b0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      cap_en_q    <= cap_en_d;
      frame_cnt_q <= frame_cnt_d;
      irq_q       <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= pix_data;
    end
  end

  assign irq_frame = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] pix_head;
  logic [7:0]       count8;
  logic [31:0]      status_word;

  assign pix_head    = fifo_q[rd_ptr_q];
  assign count8      = 8'(count_q);
  assign status_word = {frame_cnt_q, count8, 5'b0, ovf_q, full, empty};

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (reg_sel)
        REG_STATUS: ReadData = status_word;
        REG_PIX:    ReadData = empty ? 32'd0 : 32'(pix_head);
        REG_POP:    ReadData = 32'd0;
        REG_CTRL:   ReadData = {31'd0, cap_en_q};
        default:    ReadData = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_data_bus.sv
// Self-checking bench for arm_data_bus: a pixel scoreboard queue plus a small
// model of overflow, capture enable and frame count predicts every readback.
module tb_arm_data_bus;

  localparam int DEPTH = 16;

  localparam logic [31:0] A_STATUS = 32'h1000;
  localparam logic [31:0] A_PIX    = 32'h1004;
  localparam logic [31:0] A_POP    = 32'h1008;
  localparam logic [31:0] A_CTRL   = 32'h100C;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        write_enable;
  logic [31:0] ReadData;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic        frame_start;
  logic        irq_frame;

  arm_data_bus #(.RAM_WORDS(1024), .FIFO_DEPTH(DEPTH), .PIX_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .write_enable(write_enable),
    .ReadData    (ReadData),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .frame_start (frame_start),
    .irq_frame   (irq_frame)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  logic [7:0]  sb[$];
  logic        m_cap_en;
  logic        m_ovf;
  logic [15:0] m_frame;

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(sb.size());
    return {m_frame, c, 5'b0, m_ovf, (sb.size() == DEPTH), (sb.size() == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    ALUResult    = a;
    WriteData    = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    ALUResult = a;
    #1;
    d = ReadData;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    m_cap_en = 1'b0;
    m_ovf    = 1'b0;
    m_frame  = '0;
  endtask

  task automatic push_pix(input logic [7:0] v);
    logic exp_rdy;
    exp_rdy   = m_cap_en && (sb.size() < DEPTH);
    pix_valid = 1'b1;
    pix_data  = v;
    #1;
    tests_run++;
    if (pix_ready !== exp_rdy) begin
      fails++;
      $display("FAIL push_ready pix=%h got %b exp %b", v, pix_ready, exp_rdy);
    end
    if (exp_rdy) sb.push_back(v);
    else if (m_cap_en) m_ovf = 1'b1;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    logic [31:0] d;
    while (sb.size() > 0) begin
      bus_read(A_PIX, d);
      tests_run++;
      if (d !== {24'd0, sb[0]}) begin
        fails++;
        $display("FAIL drain_head got %h exp %h", d, {24'd0, sb[0]});
      end
      bus_write(A_POP, 32'd0);
      void'(sb.pop_front());
    end
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL drain_status got %h exp %h", d, exp_status());
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick();
    tick();
    do_reset();
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      fails++;
      $display("FAIL reset_status got %h exp %h", d, 32'h1);
    end
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL reset_ctrl got %h exp 0", d);
    end
    tests_run++;
    if (pix_ready !== 1'b0 || irq_frame !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs pix_ready=%b irq=%b exp 0 0", pix_ready, irq_frame);
    end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    bus_write(32'h14, 32'h1234_5678);
    bus_write(32'h10, 32'hDEAD_BEEF);
    bus_read(32'h10, d);
    tests_run++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_load got %h exp deadbeef", d);
    end
    bus_read(32'h13, d);
    tests_run++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_byte_offset got %h exp deadbeef", d);
    end
    bus_read(32'h14, d);
    tests_run++;
    if (d !== 32'h1234_5678) begin
      fails++;
      $display("FAIL ram_neighbour got %h exp 12345678", d);
    end
    bus_write(32'hFFC, 32'hCAFE_F00D);
    bus_write(32'h2000, 32'h5555_AAAA);
    bus_read(32'h2000, d);
    tests_run++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_read got %h exp 0", d);
    end
    bus_read(32'hFFC, d);
    tests_run++;
    if (d !== 32'hCAFE_F00D) begin
      fails++;
      $display("FAIL ram_top got %h exp cafef00d", d);
    end
  endtask

  task automatic test_capture();
    logic [31:0] d;
    ALUResult    = A_CTRL;
    WriteData    = 32'h1;
    write_enable = 1'b1;
    #1;
    tests_run++;
    if (pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL cap_en_delay got %b exp 0", pix_ready);
    end
    tick();
    write_enable = 1'b0;
    m_cap_en = 1'b1;
    push_pix(8'h11);
    push_pix(8'h22);
    push_pix(8'h33);
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status() || d[15:8] !== 8'd3) begin
      fails++;
      $display("FAIL capture_status got %h exp %h", d, exp_status());
    end
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h11) begin
      fails++;
      $display("FAIL capture_head got %h exp 11", d);
    end
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h11) begin
      fails++;
      $display("FAIL read_no_pop got %h exp 11", d);
    end
    bus_write(A_POP, 32'h0);
    void'(sb.pop_front());
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h22) begin
      fails++;
      $display("FAIL pop_head got %h exp 22", d);
    end
    drain();
    bus_write(A_POP, 32'h0);
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL pop_empty got %h exp %h", d, exp_status());
    end
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL empty_pix got %h exp 0", d);
    end
  endtask

  task automatic test_full();
    logic [31:0] d;
    for (int i = 0; i < DEPTH + 1; i++) push_pix(8'hA0 + 8'(i));
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status() || d[2:1] !== 2'b11) begin
      fails++;
      $display("FAIL full_status got %h exp %h", d, exp_status());
    end
    bus_write(A_CTRL, 32'h3);
    m_ovf = 1'b0;
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL ovf_clear got %h exp %h", d, exp_status());
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) push_pix(8'h50 + 8'(i));
    pix_valid = 1'b1;
    pix_data  = 8'h44;
    bus_write(A_POP, 32'h0);
    pix_valid = 1'b0;
    void'(sb.pop_front());
    sb.push_back(8'h44);
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status() || d[15:8] !== 8'd5) begin
      fails++;
      $display("FAIL simul_count got %h exp %h", d, exp_status());
    end
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h51) begin
      fails++;
      $display("FAIL simul_head got %h exp 51", d);
    end
    drain();
  endtask

  task automatic test_flush();
    logic [31:0] d;
    for (int i = 0; i < DEPTH; i++) push_pix(8'hC0 + 8'(i));
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    bus_write(A_CTRL, 32'h3);
    pix_valid = 1'b0;
    m_ovf = 1'b1;
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL set_beats_clear got %h exp %h", d, exp_status());
    end
    bus_write(A_CTRL, 32'h5);
    sb.delete();
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL flush_keeps_ovf got %h exp %h", d, exp_status());
    end
    for (int i = 0; i < 3; i++) push_pix(8'h70 + 8'(i));
    ALUResult    = A_CTRL;
    WriteData    = 32'h5;
    write_enable = 1'b1;
    pix_valid    = 1'b1;
    pix_data     = 8'h99;
    #1;
    tests_run++;
    if (pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_blocks_push got %b exp 0", pix_ready);
    end
    tick();
    write_enable = 1'b0;
    pix_valid    = 1'b0;
    sb.delete();
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL flush_count got %h exp %h", d, exp_status());
    end
    push_pix(8'h3C);
    bus_read(A_PIX, d);
    tests_run++;
    if (d !== 32'h3C) begin
      fails++;
      $display("FAIL post_flush_head got %h exp 3c", d);
    end
    bus_write(A_CTRL, 32'h3);
    m_ovf = 1'b0;
    drain();
  endtask

  task automatic test_frame();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      m_frame++;
      tests_run++;
      if (irq_frame !== 1'b1) begin
        fails++;
        $display("FAIL irq_pulse%0d got %b exp 1", i, irq_frame);
      end
      tick();
      tests_run++;
      if (irq_frame !== 1'b0) begin
        fails++;
        $display("FAIL irq_width%0d got %b exp 0", i, irq_frame);
      end
    end
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status() || d[31:16] !== 16'd3) begin
      fails++;
      $display("FAIL frame_cnt got %h exp %h", d, exp_status());
    end
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
    m_frame = m_frame + 16'd2;
    tests_run++;
    if (irq_frame !== 1'b1) begin
      fails++;
      $display("FAIL irq_b2b got %b exp 1", irq_frame);
    end
    tick();
    bus_write(A_CTRL, 32'h0);
    m_cap_en = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tests_run++;
    if (irq_frame !== 1'b0) begin
      fails++;
      $display("FAIL irq_disabled got %b exp 0", irq_frame);
    end
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status()) begin
      fails++;
      $display("FAIL frame_disabled got %h exp %h", d, exp_status());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    bus_write(A_CTRL, 32'h1);
    m_cap_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      m_frame++;
    end
    for (int i = 0; i < 8; i++) push_pix(8'h80 + 8'(i));
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== exp_status() || d !== 32'h0002_0800) begin
      fails++;
      $display("FAIL pre_reset got %h exp 00020800", d);
    end
    do_reset();
    bus_read(A_STATUS, d);
    tests_run++;
    if (d !== 32'h0000_0001) begin
      fails++;
      $display("FAIL mid_reset_status got %h exp 00000001", d);
    end
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0 || pix_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_ctrl got %h ready %b exp 0 0", d, pix_ready);
    end
    bus_read(32'h10, d);
    tests_run++;
    if (d !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL ram_survives_reset got %h exp deadbeef", d);
    end
  endtask

  initial begin
    reset        = 1'b1;
    ALUResult    = '0;
    WriteData    = '0;
    write_enable = 1'b0;
    pix_valid    = 1'b0;
    pix_data     = '0;
    frame_start  = 1'b0;
    m_cap_en     = 1'b0;
    m_ovf        = 1'b0;
    m_frame      = '0;
    test_reset();
    test_ram();
    test_capture();
    test_full();
    test_back_to_back();
    test_flush();
    test_frame();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
